instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Packs RV32I fields (opcode, rd, rs1, rs2, funct3, funct7, signed imm) into 32-bit instruction words.
//  Exact inverse of the CPU immediate-extraction path: imm bits are scattered per I/S/B/U/J format.
//  Sits between the test/boot program source and instruction-memory write port.
//  2-stage valid/ready pipeline, write-address counter, immediate range/alignment checking.
// PARAMETERS
//  ADDR_W     10  word-address width of out_addr; wraps at 2**ADDR_W-1 -> 0
//  ERR_CNT_W  8   width of saturating err_count
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       field bundle valid
//  in_ready   out  1       encoder can accept bundle this cycle
//  in_opcode  in   7       RV32I opcode; selects format
//  in_rd      in   5       destination reg
//  in_rs1     in   5       source reg 1
//  in_rs2     in   5       source reg 2
//  in_funct3  in   3       funct3
//  in_funct7  in   7       funct7 (R-type only)
//  in_imm     in   32      signed immediate (byte offset; U-type: full value, low 12 bits must be 0)
//  out_valid  out  1       encoded word valid
//  out_ready  in   1       downstream accepts word
//  out_instr  out  32      encoded instruction
//  out_addr   out  ADDR_W  word address for this beat
//  out_err    out  1       imm out of range / misaligned / unknown opcode
//  err_count  out  ERR_CNT_W  saturating count of accepted beats with out_err=1
// BEHAVIOUR
//  Reset: in_ready=1 in the cycle after reset; out_valid=0, out_instr=0, out_addr=0, out_err=0, err_count=0.
//  Handshake: transfer on valid&&ready. Valid never depends on ready. Once asserted, valid and data stay stable until accepted.
//  Stage S1 registers fields. Stage S2 registers packed word and err.
//  Latency: input accept at cycle N -> out_valid at N+2 with no backpressure.
//  Throughput 1/cycle. Stage advances when its next stage is empty or being drained.
//  in_ready = !s1_valid || !s2_valid || out_ready (combinational, no bubble).
//  Format map (opcode -> fmt):
//    0110011 -> R: {f7,rs2,rs1,f3,rd,op}.
//    0000011, 0010011, 1100111 -> I: imm[11:0] in [31:20].
//    0100011 -> S: imm[11:5] in [31:25]; imm[4:0] in [11:7].
//    1100011 -> B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
//    0110111, 0010111 -> U: [31:12]=imm[31:12].
//    1101111 -> J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
//  Fields unused by a format are ignored. rs2/funct7 are not placed in I-type; I-shift funct7 is supplied via in_imm[11:5].
//  Range checks (err=1 on violation):
//    I/S: -2048..2047.
//    B: -4096..4094, imm[0]=0.
//    J: -1048576..1048574, imm[0]=0.
//    U: imm[11:0]=0.
//  On violation the word is still packed from the truncated bits.
//  Unknown opcode: out_instr=32'h0000_0013 (NOP), out_err=1.
//  out_addr: address of the current output beat.
//    Increments by 1 after each accepted output beat; wraps 2**ADDR_W-1 -> 0 silently.
//  err_count: +1 per accepted beat with out_err=1; saturates at all-ones.
//  Simultaneous in accept and out accept: both occur; pipeline occupancy is unchanged.
//  Reset mid-operation: all in-flight beats dropped, counters cleared, no out_valid the cycle after.
// STRUCTURE
//  Package instr_enc_pkg:
//    typedef enum fmt_e {FMT_R,FMT_I,FMT_S,FMT_B,FMT_U,FMT_J,FMT_BAD};
//    opcode localparams (OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG);
//    NOP constant; imm range constants.
//  One sub-module: instr_pack.
//    Combinational fmt decode + bit packing + range check.
//    Instantiated between S1 and S2.
//  Top holds pipeline regs, handshake, address and error counters.
// TESTING
//  1 ADDI x1,x0,5 (op 0010011, rd1, f3 0, imm 5) -> 0x00500093 at addr 0, err 0, 2 cycles later.
//  2 Back-to-back SW x2,8(x1) -> 0x0020A423; BEQ x0,x0,-4 -> 0xFE000EE3; JAL x1,+2048 -> 0x001000EF; LUI x5,0x12345000 -> 0x123452B7.
//    Addrs 0..3, one beat per cycle.
//  3 ADDI imm=4096 -> err=1, err_count=1; BEQ imm=3 -> err=1; opcode 1111111 -> 0x00000013, err=1, err_count=3.
//  4 Backpressure: out_ready=0 for 4 cycles while 3 bundles offered.
//    in_ready drops after 2 accepts; out_instr stable; all 3 words emerge in order with no loss/dup.
//  5 ADDR_W=2: 5 accepted beats -> out_addr 0,1,2,3,0.
//    ERR_CNT_W=2: 5 err beats -> err_count saturates at 3.
//  6 reset asserted with 2 beats in flight -> next cycle out_valid=0, out_addr=0, err_count=0; encoding resumes correctly.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package instr_enc_pkg;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam int IMM12_MIN = -2048;
   localparam int IMM12_MAX = 2047;
   localparam int IMM13_MIN = -4096;
   localparam int IMM13_MAX = 4094;
   localparam int IMM21_MIN = -1048576;
   localparam int IMM21_MAX = 1048574;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } fields_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational format decode, immediate scatter and range/alignment check.
module instr_pack
   import instr_enc_pkg::*;
(
   input  fields_t     fields_i,
   output logic [31:0] instr_o,
   output logic        err_o
);

   fmt_e        fmt;
   logic [31:0] imm;
   int          imm_s;

   assign imm   = fields_i.imm;
   assign imm_s = $signed(fields_i.imm);

   always_comb begin
      case (fields_i.opcode)
         OP_REG:                   fmt = FMT_R;
         OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
         OP_STORE:                 fmt = FMT_S;
         OP_BRANCH:                fmt = FMT_B;
         OP_LUI, OP_AUIPC:         fmt = FMT_U;
         OP_JAL:                   fmt = FMT_J;
         default:                  fmt = FMT_BAD;
      endcase
   end

   // Out-of-range immediates still pack from their truncated low bits.
   always_comb begin
      instr_o = NOP;
      err_o   = 1'b0;
      case (fmt)
         FMT_R: instr_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3,
                           fields_i.rd, fields_i.opcode};
         FMT_I: begin
            instr_o = {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, fields_i.opcode};
            err_o   = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
         end
         FMT_S: begin
            instr_o = {imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3, imm[4:0],
                       fields_i.opcode};
            err_o   = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
         end
         FMT_B: begin
            instr_o = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                       imm[4:1], imm[11], fields_i.opcode};
            err_o   = (imm_s < IMM13_MIN) || (imm_s > IMM13_MAX) || imm[0];
         end
         FMT_U: begin
            instr_o = {imm[31:12], fields_i.rd, fields_i.opcode};
            err_o   = |imm[11:0];
         end
         FMT_J: begin
            instr_o = {imm[20], imm[10:1], imm[11], imm[19:12], fields_i.rd, fields_i.opcode};
            err_o   = (imm_s < IMM21_MIN) || (imm_s > IMM21_MAX) || imm[0];
         end
         default: err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready encoder feeding the instruction-memory write port,
// with a wrapping word-address counter and a saturating error counter.
module instr_encoder
   import instr_enc_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           in_opcode,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [2:0]           in_funct3,
   input  logic [6:0]           in_funct7,
   input  logic [31:0]          in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic [ADDR_W-1:0]    out_addr,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic                 s1_valid_q, s1_valid_d;
   fields_t              s1_q, s1_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [31:0]          instr_q, instr_d;
   logic                 err_q, err_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic        s2_free;
   logic        in_fire;
   logic        out_fire;
   logic [31:0] pack_instr;
   logic        pack_err;

   assign s2_free  = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_free;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = s2_valid_q && out_ready;

   instr_pack u_pack (
      .fields_i (s1_q),
      .instr_o  (pack_instr),
      .err_o    (pack_err)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      s2_valid_d = s2_valid_q;
      instr_d    = instr_q;
      err_d      = err_q;
      addr_d     = addr_q;
      err_cnt_d  = err_cnt_q;

      if (s2_free) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            instr_d = pack_instr;
            err_d   = pack_err;
         end
      end

      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_d       = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                        funct3: in_funct3, funct7: in_funct7, imm: in_imm};
      end else if (s2_free) begin
         s1_valid_d = 1'b0;
      end

      if (out_fire) begin
         addr_d = addr_q + ADDR_W'(1);
         if (err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         instr_q    <= '0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         err_cnt_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_q       <= s1_d;
         s2_valid_q <= s2_valid_d;
         instr_q    <= instr_d;
         err_q      <= err_d;
         addr_q     <= addr_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_instr = instr_q;
   assign out_err   = err_q;
   assign out_addr  = addr_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: a default-width and a narrow-counter
// instance share stimulus and are checked against a field-placement model.
module tb_instr_encoder;

   localparam int AW  = 10;
   localparam int EW  = 8;
   localparam int AWS = 2;
   localparam int EWS = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             out_ready;
   logic [6:0]       in_opcode;
   logic [4:0]       in_rd, in_rs1, in_rs2;
   logic [2:0]       in_funct3;
   logic [6:0]       in_funct7;
   logic [31:0]      in_imm;

   logic             in_ready, out_valid, out_err;
   logic [31:0]      out_instr;
   logic [AW-1:0]    out_addr;
   logic [EW-1:0]    err_count;
   logic             in_ready_s, out_valid_s, out_err_s;
   logic [31:0]      out_instr_s;
   logic [AWS-1:0]   out_addr_s;
   logic [EWS-1:0]   err_count_s;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(AW), .ERR_CNT_W(EW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
   );

   instr_encoder #(.ADDR_W(AWS), .ERR_CNT_W(EWS)) dut_s (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_instr(out_instr_s),
      .out_addr(out_addr_s), .out_err(out_err_s), .err_count(err_count_s)
   );

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic        has_dir;
      logic [31:0] dir;
      logic        dir_err;
   } bundle_t;

   typedef struct {
      logic [31:0] instr;
      logic        err;
      int          acc;
      logic        has_dir;
      logic [31:0] dir;
      logic        dir_err;
   } entry_t;

   bundle_t src_q[$];
   entry_t  exp_q[$];
   bundle_t cur;

   int   n_chk = 0, n_pass = 0;
   int   cyc = 0, last_stall = -1, n_out = 0, n_err = 0, n_acc = 0;
   logic hold_prev = 1'b0;

   logic [6:0] ops[9] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
   int bnd[14] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                   -1048577, -1048576, 1048574, 1048575, 1048576};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Take n bits of v starting at bit lo and place them at bit pos.
   function automatic logic [31:0] put(input logic [31:0] v, input int lo, input int n, input int pos);
      logic [31:0] m;
      m = (32'd1 << n) - 32'd1;
      return ((v >> lo) & m) << pos;
   endfunction

   function automatic logic [32:0] ref_encode(input bundle_t b);
      int          imm;
      logic [31:0] u, w, core;
      logic        e;
      imm  = $signed(b.imm);
      u    = b.imm;
      e    = 1'b0;
      core = put(32'(b.rs1), 0, 5, 15) | put(32'(b.f3), 0, 3, 12) | 32'(b.op);
      case (b.op)
         7'h33: w = core | put(32'(b.f7), 0, 7, 25) | put(32'(b.rs2), 0, 5, 20) | put(32'(b.rd), 0, 5, 7);
         7'h03, 7'h13, 7'h67: begin
            w = core | put(u, 0, 12, 20) | put(32'(b.rd), 0, 5, 7);
            e = imm < -2048 || imm > 2047;
         end
         7'h23: begin
            w = core | put(32'(b.rs2), 0, 5, 20) | put(u, 5, 7, 25) | put(u, 0, 5, 7);
            e = imm < -2048 || imm > 2047;
         end
         7'h63: begin
            w = core | put(32'(b.rs2), 0, 5, 20) | put(u, 12, 1, 31) | put(u, 5, 6, 25)
                     | put(u, 1, 4, 8) | put(u, 11, 1, 7);
            e = imm < -4096 || imm > 4094 || (imm % 2 != 0);
         end
         7'h37, 7'h17: begin
            w = put(u, 12, 20, 12) | put(32'(b.rd), 0, 5, 7) | 32'(b.op);
            e = (u % 4096) != 0;
         end
         7'h6F: begin
            w = put(u, 20, 1, 31) | put(u, 1, 10, 21) | put(u, 11, 1, 20) | put(u, 12, 8, 12)
              | put(32'(b.rd), 0, 5, 7) | 32'(b.op);
            e = imm < -1048576 || imm > 1048574 || (imm % 2 != 0);
         end
         default: begin
            w = 32'h13;
            e = 1'b1;
         end
      endcase
      return {e, w};
   endfunction

   function automatic bundle_t rand_bundle();
      bundle_t b;
      b.op  = ($urandom_range(9) == 0) ? 7'($urandom) : ops[$urandom_range(8)];
      b.rd  = 5'($urandom);
      b.rs1 = 5'($urandom);
      b.rs2 = 5'($urandom);
      b.f3  = 3'($urandom);
      b.f7  = 7'($urandom);
      case ($urandom_range(3))
         0:       b.imm = $urandom;
         1:       b.imm = 32'(int'($urandom_range(8000)) - 4000);
         2:       b.imm = 32'(bnd[$urandom_range(13)]);
         default: b.imm = $urandom & 32'hFFFF_F000;
      endcase
      b.has_dir = 1'b0;
      b.dir     = '0;
      b.dir_err = 1'b0;
      return b;
   endfunction

   task automatic push_dir(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm, input logic [31:0] word, input logic err);
      bundle_t b;
      b = '{op: op, rd: rd, rs1: rs1, rs2: rs2, f3: f3, f7: f7, imm: imm,
            has_dir: 1'b1, dir: word, dir_err: err};
      src_q.push_back(b);
   endtask

   task automatic cycle(input int p_valid, input int p_ready);
      entry_t      e;
      logic [32:0] r;
      logic        ir_exp, fire_in, fire_out;
      if (!in_valid && src_q.size() > 0 && $urandom_range(99) < p_valid) begin
         cur       = src_q.pop_front();
         in_opcode = cur.op;  in_rd = cur.rd;   in_rs1 = cur.rs1; in_rs2 = cur.rs2;
         in_funct3 = cur.f3;  in_funct7 = cur.f7; in_imm = cur.imm;
         in_valid  = 1'b1;
      end
      out_ready = ($urandom_range(99) < p_ready);
      @(negedge clk);
      ir_exp = (exp_q.size() < 2) || out_ready;
      check("in_ready", 32'(in_ready), 32'(ir_exp));
      check("in_ready_s", 32'(in_ready_s), 32'(ir_exp));
      if (hold_prev) check("hold_valid", 32'(out_valid), 32'd1);
      if (exp_q.size() == 0) begin
         check("idle_valid", 32'(out_valid), 32'd0);
         check("idle_valid_s", 32'(out_valid_s), 32'd0);
      end else if (cyc < exp_q[0].acc + 2) begin
         check("early_valid", 32'(out_valid), 32'd0);
      end else if (cyc == exp_q[0].acc + 2 && exp_q[0].acc > last_stall) begin
         check("latency", 32'(out_valid), 32'd1);
      end
      fire_out = out_valid && out_ready;
      if (out_valid && exp_q.size() > 0) begin
         e = exp_q[0];
         check("instr", out_instr, e.instr);
         check("err", 32'(out_err), 32'(e.err));
         check("addr", 32'(out_addr), 32'(n_out % (1 << AW)));
         check("err_count", 32'(err_count), 32'((n_err > 255) ? 255 : n_err));
         check("valid_s", 32'(out_valid_s), 32'd1);
         check("instr_s", out_instr_s, e.instr);
         check("err_s", 32'(out_err_s), 32'(e.err));
         check("addr_s", 32'(out_addr_s), 32'(n_out % (1 << AWS)));
         check("err_count_s", 32'(err_count_s), 32'((n_err > 3) ? 3 : n_err));
         if (e.has_dir) begin
            check("dir_word", out_instr, e.dir);
            check("dir_err", 32'(out_err), 32'(e.dir_err));
         end
         if (fire_out) begin
            void'(exp_q.pop_front());
            n_out++;
            if (e.err) n_err++;
         end
      end
      fire_in = in_valid && in_ready;
      if (fire_in) begin
         r = ref_encode(cur);
         e = '{instr: r[31:0], err: r[32], acc: cyc, has_dir: cur.has_dir,
               dir: cur.dir, dir_err: cur.dir_err};
         exp_q.push_back(e);
         n_acc++;
      end
      if (!out_ready) last_stall = cyc;
      hold_prev = out_valid && !out_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (fire_in) in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc++;
      exp_q.delete();
      n_out = 0; n_err = 0; hold_prev = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_valid_s", 32'(out_valid_s), 32'd0);
      check("rst_instr", out_instr, 32'd0);
      check("rst_err", 32'(out_err), 32'd0);
      check("rst_addr", 32'(out_addr), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      cyc++;
      last_stall = cyc - 1;
   endtask

   initial begin
      int guard, acc0;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_funct3 = '0; in_funct7 = '0; in_imm = '0;
      do_reset();

      // ADDI x1,x0,5 (rs2/funct7 garbage must be ignored)
      push_dir(7'h13, 5'd1, 5'd0, 5'd9, 3'd0, 7'h7F, 32'd5, 32'h0050_0093, 1'b0);
      repeat (4) cycle(100, 100);

      do_reset();
      push_dir(7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8, 32'h0020_A423, 1'b0);
      push_dir(7'h63, 5'd31, 5'd0, 5'd0, 3'd0, 7'h7F, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
      push_dir(7'h6F, 5'd1, 5'd7, 5'd9, 3'd5, 7'h7F, 32'd2048, 32'h0010_00EF, 1'b0);
      push_dir(7'h37, 5'd5, 5'd3, 5'd9, 3'd1, 7'h7F, 32'h1234_5000, 32'h1234_52B7, 1'b0);
      repeat (7) cycle(100, 100);

      push_dir(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096, 32'h0000_0093, 1'b1);
      push_dir(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3, 32'h0000_0163, 1'b1);
      push_dir(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 32'h0000_0013, 1'b1);
      push_dir(7'h7F, 5'd3, 5'd4, 5'd5, 3'd6, 7'h11, 32'd1, 32'h0000_0013, 1'b1);
      push_dir(7'h00, 5'd3, 5'd4, 5'd5, 3'd6, 7'h11, 32'd1, 32'h0000_0013, 1'b1);
      repeat (8) cycle(100, 100);
      check("err_count_total", 32'(err_count), 32'd5);
      check("err_count_sat_s", 32'(err_count_s), 32'd3);
      check("addr_total", 32'(out_addr), 32'd9);
      check("addr_wrap_s", 32'(out_addr_s), 32'd1);

      // Backpressure: three bundles offered while the output is stalled
      for (int i = 0; i < 3; i++) src_q.push_back(rand_bundle());
      acc0 = n_acc;
      repeat (4) cycle(100, 0);
      check("bp_accepts", 32'(n_acc - acc0), 32'd2);
      repeat (6) cycle(100, 100);
      check("bp_drained", 32'(exp_q.size()), 32'd0);

      // Reset with two beats in flight
      for (int i = 0; i < 2; i++) src_q.push_back(rand_bundle());
      repeat (2) cycle(100, 0);
      do_reset();
      push_dir(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h0050_0093, 1'b0);
      repeat (4) cycle(100, 100);
      check("post_rst_addr", 32'(out_addr), 32'd1);

      for (int i = 0; i < 1500; i++) src_q.push_back(rand_bundle());
      guard = 0;
      while ((src_q.size() > 0 || in_valid || exp_q.size() > 0) && guard < 20000) begin
         cycle(70, 70);
         guard++;
      end
      check("random_drain", 32'(src_q.size() + exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
